// File: rtl/arm_pkg.sv
// Shared definitions for the ARM fetch stage: FSM encoding and default constants.
package arm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEF = 32'hE1A00000;
    localparam int unsigned TO_CNT_W      = 8;

endpackage

// File: rtl/arm_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and memory.
interface arm_fetch_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  mem_err
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output mem_err
    );

endinterface

// File: rtl/arm_fetch_unit.sv
// Fetch stage: one-entry tagged buffer in front of a variable-latency instruction memory,
// with sticky fault on misaligned pc, memory error or request timeout.
module arm_fetch_unit
    import arm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic                     flush,
    output logic [31:0]              instr,
    output logic                     instr_valid,
    output logic                     stall,
    output logic                     fetch_fault,
    arm_fetch_unit_if.master         mem
);

    localparam logic [TO_CNT_W-1:0] LP_TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t        r_state;
    logic                r_buf_valid;
    logic [29:0]         r_buf_tag;
    logic [31:0]         r_buf_data;
    logic [31:0]         r_req_addr;
    logic                r_drop;
    logic [TO_CNT_W-1:0] r_cnt;
    logic                r_mem_req;

    fetch_state_t        w_state_nxt;
    logic                w_buf_valid_nxt;
    logic [29:0]         w_buf_tag_nxt;
    logic [31:0]         w_buf_data_nxt;
    logic [31:0]         w_req_addr_nxt;
    logic                w_drop_nxt;
    logic [TO_CNT_W-1:0] w_cnt_nxt;
    logic                w_mem_req_nxt;
    logic                w_hit;
    logic                w_misaligned;

    assign w_hit        = r_buf_valid && (r_buf_tag == pc[31:2]) && !flush && (r_state != ST_FAULT);
    assign w_misaligned = (pc[1:0] != 2'b00);

    assign instr_valid  = w_hit;
    assign instr        = w_hit ? r_buf_data : NOP_INSTR;
    assign stall        = !w_hit;
    assign fetch_fault  = (r_state == ST_FAULT);
    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_req_addr;

    always_comb begin
        w_state_nxt     = r_state;
        w_buf_valid_nxt = r_buf_valid;
        w_buf_tag_nxt   = r_buf_tag;
        w_buf_data_nxt  = r_buf_data;
        w_req_addr_nxt  = r_req_addr;
        w_drop_nxt      = r_drop;
        w_cnt_nxt       = r_cnt;
        w_mem_req_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_buf_valid_nxt = 1'b0;
                end
                if (w_misaligned) begin
                    w_state_nxt     = ST_FAULT;
                    w_buf_valid_nxt = 1'b0;
                end else if (!w_hit) begin
                    w_req_addr_nxt = {pc[31:2], 2'b00};
                    w_cnt_nxt      = '0;
                    w_drop_nxt     = 1'b0;
                    w_mem_req_nxt  = 1'b1;
                    w_state_nxt    = ST_REQ;
                end
            end

            ST_REQ: begin
                w_mem_req_nxt = 1'b1;
                w_cnt_nxt     = r_cnt + 1'b1;
                if (flush) begin
                    w_drop_nxt      = 1'b1;
                    w_buf_valid_nxt = 1'b0;
                end
                if (mem.mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    if (mem.mem_err) begin
                        w_state_nxt     = ST_FAULT;
                        w_buf_valid_nxt = 1'b0;
                    end else begin
                        // A flush coinciding with the ack drops the data just like an earlier one.
                        if (!r_drop && !flush) begin
                            w_buf_tag_nxt   = r_req_addr[31:2];
                            w_buf_data_nxt  = mem.mem_rdata;
                            w_buf_valid_nxt = 1'b1;
                        end
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_cnt == LP_TO_LAST) begin
                    w_mem_req_nxt   = 1'b0;
                    w_state_nxt     = ST_FAULT;
                    w_buf_valid_nxt = 1'b0;
                end
            end

            ST_FAULT: begin
                w_buf_valid_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
            r_req_addr  <= '0;
            r_drop      <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_tag   <= w_buf_tag_nxt;
            r_buf_data  <= w_buf_data_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_drop      <= w_drop_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_req   <= w_mem_req_nxt;
        end
    end

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Self-checking bench for arm_fetch_unit: behavioural memory responder, vector table and
// hand-written corner-case sequences, with a scoreboard of expected fetched words.
module tb_arm_fetch_unit;

    localparam int unsigned TO  = 255;
    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        fetch_fault;

    arm_fetch_unit_if u_mem_if ();

    arm_fetch_unit #(
        .TIMEOUT_CYCLES(TO),
        .NOP_INSTR     (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .flush      (flush),
        .instr      (instr),
        .instr_valid(instr_valid),
        .stall      (stall),
        .fetch_fault(fetch_fault),
        .mem        (u_mem_if)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned mem_lat    = 1;
    logic        mem_err_en = 1'b0;
    int unsigned req_cycles = 0;
    int unsigned req_count  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] pc;
        int unsigned lat;
        int unsigned exp_req;
        logic [31:0] exp_instr;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A01005;
        return (a * 32'h9E3779B1) ^ 32'h12345678;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Samples until instr_valid (bounded), then pops the scoreboard and compares.
    task automatic wait_valid(input int unsigned max, input logic [31:0] exp_addr,
                              output int unsigned n, output int unsigned nreq);
        exp_t e;
        logic seen;
        seen = 1'b0;
        nreq = 0;
        n    = 0;
        for (int unsigned k = 0; k < max; k++) begin
            sample();
            if (u_mem_if.mem_req) begin
                nreq++;
                check("mem_addr_stable", u_mem_if.mem_addr, exp_addr);
            end
            if (instr_valid) begin
                seen = 1'b1;
                n    = k;
                break;
            end
        end
        e = sb.pop_front();
        check("valid_within_bound", {31'b0, seen}, 32'd1);
        if (seen) begin
            check("instr", instr, e.instr);
            check("stall_low", {31'b0, stall}, 32'd0);
        end
    endtask

    // Memory responder: acks on the mem_lat-th cycle of each request (mem_lat=0: never).
    initial begin
        u_mem_if.mem_ack   = 1'b0;
        u_mem_if.mem_rdata = '0;
        u_mem_if.mem_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (u_mem_if.mem_req) begin
                if (req_cycles == 0) req_count++;
                req_cycles++;
                if (mem_lat != 0 && req_cycles == mem_lat) begin
                    u_mem_if.mem_ack   = 1'b1;
                    u_mem_if.mem_rdata = memword(u_mem_if.mem_addr);
                    u_mem_if.mem_err   = mem_err_en;
                end else begin
                    u_mem_if.mem_ack   = 1'b0;
                    u_mem_if.mem_rdata = '0;
                    u_mem_if.mem_err   = 1'b0;
                end
            end else begin
                req_cycles         = 0;
                u_mem_if.mem_ack   = 1'b0;
                u_mem_if.mem_err   = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        int unsigned nreq;
        int unsigned rc0;
        int unsigned fault_at;
        exp_t        e;

        vecs[0] = '{32'h0000_0100, 5, 5, memword(32'h0000_0100)};
        vecs[1] = '{32'h0000_0104, 1, 1, memword(32'h0000_0104)};
        vecs[2] = '{32'h0000_0104, 1, 0, memword(32'h0000_0104)};
        vecs[3] = '{32'h0000_0200, 3, 3, memword(32'h0000_0200)};
        vecs[4] = '{32'h0000_0000, 2, 2, 32'hE3A01005};
        vecs[5] = '{32'hFFFF_FFFC, 4, 4, memword(32'hFFFF_FFFC)};

        // Reset values
        reset = 1'b1;
        flush = 1'b0;
        pc    = 32'h0;
        #2;
        check("rst_mem_req", {31'b0, u_mem_if.mem_req}, 32'd0);
        check("rst_mem_addr", u_mem_if.mem_addr, 32'h0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd1);

        // Cold fetch
        mem_lat = 1;
        drive_cycle();
        reset = 1'b0;
        sample();
        check("cold_c0_req", {31'b0, u_mem_if.mem_req}, 32'd0);
        sample();
        check("cold_c1_req", {31'b0, u_mem_if.mem_req}, 32'd1);
        check("cold_c1_addr", u_mem_if.mem_addr, 32'h0);
        sb.push_back('{32'h0, 32'hE3A01005});
        sample();
        e = sb.pop_front();
        check("cold_c2_valid", {31'b0, instr_valid}, 32'd1);
        check("cold_c2_instr", instr, e.instr);
        check("cold_c2_stall", {31'b0, stall}, 32'd0);
        check("cold_c2_req", {31'b0, u_mem_if.mem_req}, 32'd0);
        repeat (5) sample();
        check("cold_hold_reqs", req_count, 32'd1);
        check("cold_hold_valid", {31'b0, instr_valid}, 32'd1);

        // Vector table: miss latency = ack cycle + 1, hit = same cycle with no request
        foreach (vecs[i]) begin
            drive_cycle();
            mem_lat = vecs[i].lat;
            pc      = vecs[i].pc;
            sb.push_back('{vecs[i].pc, vecs[i].exp_instr});
            rc0 = req_count;
            wait_valid(60, vecs[i].pc, n, nreq);
            check("vec_req_cycles", nreq, vecs[i].exp_req);
            check("vec_latency", n, (vecs[i].exp_req == 0) ? 32'd0 : vecs[i].exp_req + 1);
            check("vec_req_count", req_count - rc0, (vecs[i].exp_req == 0) ? 32'd0 : 32'd1);
        end

        // PC change mid-request: stale 0x8 completes, one IDLE cycle, then 0xC
        drive_cycle();
        mem_lat = 3;
        pc      = 32'h8;
        rc0     = req_count;
        sample();
        sample();
        check("pcchg_c1_req", {31'b0, u_mem_if.mem_req}, 32'd1);
        check("pcchg_c1_addr", u_mem_if.mem_addr, 32'h8);
        pc = 32'hC;
        sample();
        check("pcchg_c2_addr", u_mem_if.mem_addr, 32'h8);
        check("pcchg_c2_valid", {31'b0, instr_valid}, 32'd0);
        sample();
        check("pcchg_c3_req", {31'b0, u_mem_if.mem_req}, 32'd1);
        sample();
        check("pcchg_c4_req", {31'b0, u_mem_if.mem_req}, 32'd0);
        check("pcchg_c4_valid", {31'b0, instr_valid}, 32'd0);
        sample();
        check("pcchg_c5_req", {31'b0, u_mem_if.mem_req}, 32'd1);
        check("pcchg_c5_addr", u_mem_if.mem_addr, 32'hC);
        sb.push_back('{32'hC, memword(32'hC)});
        wait_valid(20, 32'hC, n, nreq);
        check("pcchg_reqs", req_count - rc0, 32'd2);

        // Flush during REQ: data dropped, re-request of the same word
        drive_cycle();
        mem_lat = 3;
        pc      = 32'h20;
        rc0     = req_count;
        sample();
        sample();
        check("flreq_c1_req", {31'b0, u_mem_if.mem_req}, 32'd1);
        flush = 1'b1;
        drive_cycle();
        flush = 1'b0;
        sample();
        sample();
        sample();
        check("flreq_c4_req", {31'b0, u_mem_if.mem_req}, 32'd0);
        check("flreq_c4_valid", {31'b0, instr_valid}, 32'd0);
        sample();
        check("flreq_c5_req", {31'b0, u_mem_if.mem_req}, 32'd1);
        check("flreq_c5_addr", u_mem_if.mem_addr, 32'h20);
        sb.push_back('{32'h20, memword(32'h20)});
        wait_valid(20, 32'h20, n, nreq);
        check("flreq_reqs", req_count - rc0, 32'd2);

        // Flush in IDLE on a hit
        drive_cycle();
        flush = 1'b1;
        sample();
        check("flhit_valid", {31'b0, instr_valid}, 32'd0);
        check("flhit_instr", instr, NOP);
        check("flhit_stall", {31'b0, stall}, 32'd1);
        drive_cycle();
        flush = 1'b0;
        sample();
        check("flhit_rereq", {31'b0, u_mem_if.mem_req}, 32'd1);
        sb.push_back('{32'h20, memword(32'h20)});
        wait_valid(20, 32'h20, n, nreq);

        // Flush coinciding with the ack drops the data
        drive_cycle();
        mem_lat = 1;
        pc      = 32'h24;
        sample();
        sample();
        check("flack_c1_req", {31'b0, u_mem_if.mem_req}, 32'd1);
        flush = 1'b1;
        drive_cycle();
        flush = 1'b0;
        sample();
        check("flack_c2_valid", {31'b0, instr_valid}, 32'd0);
        sample();
        check("flack_c3_rereq", {31'b0, u_mem_if.mem_req}, 32'd1);
        sb.push_back('{32'h24, memword(32'h24)});
        wait_valid(20, 32'h24, n, nreq);

        // Misaligned pc faults with no request, sticky until reset
        drive_cycle();
        pc  = 32'h6;
        rc0 = req_count;
        sample();
        check("mis_c0_fault", {31'b0, fetch_fault}, 32'd0);
        sample();
        check("mis_c1_fault", {31'b0, fetch_fault}, 32'd1);
        check("mis_c1_req", {31'b0, u_mem_if.mem_req}, 32'd0);
        drive_cycle();
        pc = 32'h24;
        repeat (3) sample();
        check("mis_sticky", {31'b0, fetch_fault}, 32'd1);
        check("mis_fault_novalid", {31'b0, instr_valid}, 32'd0);
        check("mis_noreq", req_count - rc0, 32'd0);
        do_reset();
        sample();
        check("mis_cleared", {31'b0, fetch_fault}, 32'd0);

        // Memory error with ack
        pc         = 32'h40;
        mem_lat    = 2;
        mem_err_en = 1'b1;
        do_reset();
        fault_at = 0;
        for (int unsigned k = 0; k < 20; k++) begin
            sample();
            if (fetch_fault) begin
                fault_at = k;
                break;
            end
        end
        check("err_fault_cycle", fault_at, 32'd3);
        mem_err_en = 1'b0;
        repeat (4) sample();
        check("err_sticky", {31'b0, fetch_fault}, 32'd1);
        check("err_req_low", {31'b0, u_mem_if.mem_req}, 32'd0);

        // Timeout: REQ lasts TO cycles, FAULT in the following cycle
        pc      = 32'h80;
        mem_lat = 0;
        do_reset();
        check("to_after_reset", {31'b0, fetch_fault}, 32'd0);
        sample();
        nreq     = 0;
        fault_at = 0;
        for (int unsigned k = 1; k < 400; k++) begin
            sample();
            if (fetch_fault) begin
                fault_at = k;
                break;
            end
            if (u_mem_if.mem_req) nreq++;
        end
        check("to_fault_cycle", fault_at, TO + 1);
        check("to_req_cycles", nreq, TO);
        check("to_req_low", {31'b0, u_mem_if.mem_req}, 32'd0);
        repeat (3) sample();
        check("to_sticky", {31'b0, fetch_fault}, 32'd1);

        // Asynchronous reset mid-REQ
        pc      = 32'h300;
        mem_lat = 0;
        do_reset();
        sample();
        sample();
        check("arst_pre_req", {31'b0, u_mem_if.mem_req}, 32'd1);
        sample();
        reset = 1'b1;
        #1;
        check("arst_req", {31'b0, u_mem_if.mem_req}, 32'd0);
        check("arst_addr", u_mem_if.mem_addr, 32'h0);
        check("arst_fault", {31'b0, fetch_fault}, 32'd0);
        check("arst_valid", {31'b0, instr_valid}, 32'd0);
        check("arst_stall", {31'b0, stall}, 32'd1);
        check("arst_instr", instr, NOP);
        mem_lat = 2;
        drive_cycle();
        reset = 1'b0;
        sb.push_back('{32'h300, memword(32'h300)});
        wait_valid(20, 32'h300, n, nreq);
        check("arst_refetch_lat", n, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
